// File: rtl/dtree_node_loader_if.sv
// Byte-stream configuration handshake and node-memory write port of the decision-tree loader.
interface dtree_node_loader_if #(
    parameter int unsigned AW        = 3,
    parameter int unsigned NODE_SIZE = 24
);
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [7:0]           cfg_byte;
    logic                 wr_node;
    logic [AW-1:0]        node_addr;
    logic [NODE_SIZE-1:0] node_data_in;

    // Loader side: consumes the byte stream and drives the node-write port.
    modport master (
        input  cfg_valid,
        input  cfg_byte,
        output cfg_ready,
        output wr_node,
        output node_addr,
        output node_data_in
    );

    // Environment side: produces the byte stream and observes node writes.
    modport slave (
        output cfg_valid,
        output cfg_byte,
        input  cfg_ready,
        input  wr_node,
        input  node_addr,
        input  node_data_in
    );
endinterface

// File: rtl/dtree_node_loader.sv
// Assembles checksummed node descriptors from a byte stream and writes them
// to the classifier node memory at strictly sequential addresses.
module dtree_node_loader #(
    parameter int unsigned FEATURES      = 3,
    parameter int unsigned COEFF_WIDTH   = 4,
    parameter int unsigned BIAS_WIDTH    = 10,
    parameter int unsigned MAX_CLUSTERS  = 5,
    parameter int unsigned CHANNEL_COUNT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                restart,
    dtree_node_loader_if.master cfg,
    output logic                done,
    output logic                csum_err,
    output logic [7:0]          err_count
);
    localparam int unsigned NODE_SIZE = 2 + FEATURES + (FEATURES - 1) * COEFF_WIDTH + BIAS_WIDTH + 1;
    localparam int unsigned NBYTES    = (NODE_SIZE + 7) / 8;
    localparam int unsigned BUFW      = NBYTES * 8;
    localparam int unsigned NODES     = MAX_CLUSTERS * CHANNEL_COUNT;
    localparam int unsigned AW        = (NODES > 1) ? $clog2(NODES) : 1;
    localparam int unsigned BW        = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        S_DATA  = 2'd0,
        S_CSUM  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [BW-1:0]        byte_idx_q, byte_idx_d;
    logic [7:0]           xor_q, xor_d;
    logic [BUFW-1:0]      buf_q, buf_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic [NODE_SIZE-1:0] out_q, out_d;
    logic [7:0]           err_q, err_d;
    logic                 csum_err_q, csum_err_d;
    logic                 cfg_ready_c;
    logic                 xfer_c;

    assign cfg_ready_c = (state_q == S_DATA) || (state_q == S_CSUM);
    assign xfer_c      = cfg.cfg_valid & cfg_ready_c;

    // State and datapath registers; reset discards any partial frame at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_DATA;
            byte_idx_q <= '0;
            xor_q      <= '0;
            buf_q      <= '0;
            idx_q      <= '0;
            out_q      <= '0;
            err_q      <= '0;
            csum_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            xor_q      <= xor_d;
            buf_q      <= buf_d;
            idx_q      <= idx_d;
            out_q      <= out_d;
            err_q      <= err_d;
            csum_err_q <= csum_err_d;
        end
    end

    // Next-state logic: frame assembly, checksum compare, sequential node writes.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        xor_d      = xor_q;
        buf_d      = buf_q;
        idx_d      = idx_q;
        out_d      = out_q;
        err_d      = err_q;
        csum_err_d = 1'b0;

        if (restart) begin
            // Restart wins over any byte offered in the same cycle; err_count survives.
            state_d    = S_DATA;
            byte_idx_d = '0;
            xor_d      = '0;
            idx_d      = '0;
        end else begin
            case (state_q)
                S_DATA: begin
                    if (xfer_c) begin
                        buf_d[{byte_idx_q, 3'b000} +: 8] = cfg.cfg_byte;
                        xor_d = xor_q ^ cfg.cfg_byte;
                        if (byte_idx_q == BW'(NBYTES - 1)) begin
                            byte_idx_d = '0;
                            state_d    = S_CSUM;
                        end else begin
                            byte_idx_d = byte_idx_q + BW'(1);
                        end
                    end
                end
                S_CSUM: begin
                    if (xfer_c) begin
                        xor_d = '0;
                        if (cfg.cfg_byte == xor_q) begin
                            // Padding bits above NODE_SIZE are dropped here.
                            out_d   = buf_q[NODE_SIZE-1:0];
                            state_d = S_WRITE;
                        end else begin
                            csum_err_d = 1'b1;
                            if (err_q != 8'hFF) begin
                                err_d = err_q + 8'd1;
                            end
                            state_d = S_DATA;
                        end
                    end
                end
                S_WRITE: begin
                    if (idx_q == AW'(NODES - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = S_DATA;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_DATA;
                end
            endcase
        end
    end

    // Port drive; a restart during the write cycle cancels that write.
    assign cfg.cfg_ready    = cfg_ready_c;
    assign cfg.wr_node      = (state_q == S_WRITE) && !restart;
    assign cfg.node_addr    = idx_q;
    assign cfg.node_data_in = out_q;
    assign done             = (state_q == S_DONE);
    assign csum_err         = csum_err_q;
    assign err_count        = err_q;
endmodule

// File: tb/tb_dtree_node_loader.sv
// Self-checking bench for dtree_node_loader: default 24-bit nodes plus a 20-bit
// variant fed by the same stream to exercise padding-bit handling.
module tb_dtree_node_loader;
    localparam int NB    = 3;
    localparam int NODES = 5;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       reset;
    logic       restart;
    logic       cfg_valid;
    logic [7:0] cfg_byte;
    logic       done0, csum0, done1, csum1;
    logic [7:0] errc0, errc1;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int t_first;

    dtree_node_loader_if #(.AW(3), .NODE_SIZE(24)) if0 ();
    dtree_node_loader_if #(.AW(3), .NODE_SIZE(20)) if1 ();

    assign if0.cfg_valid = cfg_valid;
    assign if0.cfg_byte  = cfg_byte;
    assign if1.cfg_valid = cfg_valid;
    assign if1.cfg_byte  = cfg_byte;

    dtree_node_loader dut0 (
        .clk(clk), .reset(reset), .restart(restart), .cfg(if0),
        .done(done0), .csum_err(csum0), .err_count(errc0)
    );

    dtree_node_loader #(.BIAS_WIDTH(6)) dut1 (
        .clk(clk), .reset(reset), .restart(restart), .cfg(if1),
        .done(done1), .csum_err(csum1), .err_count(errc1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed writes and pulses, sampled mid-cycle.
    int          wa0[$];
    logic [23:0] wd0[$];
    int          wa1[$];
    logic [19:0] wd1[$];
    int          csum_cnt0, csum_cnt1, done_cyc0;

    always @(negedge clk) begin
        if (if0.wr_node) begin
            wa0.push_back(int'(if0.node_addr));
            wd0.push_back(if0.node_data_in);
        end
        if (if1.wr_node) begin
            wa1.push_back(int'(if1.node_addr));
            wd1.push_back(if1.node_data_in);
        end
        if (csum0) csum_cnt0++;
        if (csum1) csum_cnt1++;
        if (done0 && done_cyc0 < 0) done_cyc0 = cyc;
    end

    task automatic clear_mon();
        wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
        csum_cnt0 = 0; csum_cnt1 = 0; done_cyc0 = -1; t_first = -1;
    endtask

    task automatic do_reset();
        reset = 1'b1; restart = 1'b0; cfg_valid = 1'b0; cfg_byte = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_mon();
    endtask

    // Frame = 3 data bytes LSB first + XOR checksum; bad frames get a nonzero XOR error.
    function automatic bq_t make_frame(input logic [23:0] w, input bit bad);
        bq_t q;
        logic [7:0] cs;
        q.push_back(w[7:0]); q.push_back(w[15:8]); q.push_back(w[23:16]);
        cs = w[7:0] ^ w[15:8] ^ w[23:16];
        if (bad) cs = cs ^ 8'(1 + $urandom_range(254));
        q.push_back(cs);
        return q;
    endfunction

    // Offers each byte until accepted; gap_pct is the chance of idling a cycle.
    task automatic send_bytes(input bq_t q, input int gap_pct);
        for (int i = 0; i < q.size(); i++) begin
            bit sent;
            int guard;
            sent = 1'b0; guard = 0;
            while (!sent) begin
                @(negedge clk);
                if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                    cfg_valid = 1'b0; cfg_byte = 8'($urandom);
                end else begin
                    cfg_valid = 1'b1; cfg_byte = q[i];
                    if (if0.cfg_ready) begin
                        @(posedge clk); #1;
                        sent = 1'b1;
                        if (t_first < 0) t_first = cyc;
                    end
                end
                guard++;
                if (!sent && guard > 300) begin
                    n_cmp++; n_err++;
                    $display("FAIL send_timeout: byte %0d got ready=%b want 1", i, if0.cfg_ready);
                    cfg_valid = 1'b0;
                    return;
                end
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++; if (if0.cfg_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", if0.cfg_ready); end
        n_cmp++; if (if0.wr_node !== 1'b0) begin n_err++; $display("FAIL rst_wr: got %b want 0", if0.wr_node); end
        n_cmp++; if (if0.node_addr !== 3'd0) begin n_err++; $display("FAIL rst_addr: got %0d want 0", if0.node_addr); end
        n_cmp++; if (if0.node_data_in !== 24'h0) begin n_err++; $display("FAIL rst_data: got %h want 0", if0.node_data_in); end
        n_cmp++; if (done0 !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done0); end
        n_cmp++; if (csum0 !== 1'b0) begin n_err++; $display("FAIL rst_csum: got %b want 0", csum0); end
        n_cmp++; if (errc0 !== 8'd0) begin n_err++; $display("FAIL rst_errc: got %0d want 0", errc0); end
        n_cmp++; if (if1.node_data_in !== 20'h0) begin n_err++; $display("FAIL rst_data20: got %h want 0", if1.node_data_in); end
    endtask

    task automatic test_single_node();
        bq_t q;
        do_reset();
        q = '{8'h12, 8'h34, 8'h56, 8'h70};
        send_bytes(q, 0);
        repeat (3) @(negedge clk);
        n_cmp++; if (wa0.size() !== 1) begin n_err++; $display("FAIL single_count: got %0d want 1", wa0.size()); end
        if (wa0.size() > 0) begin
            n_cmp++; if (wa0[0] !== 0) begin n_err++; $display("FAIL single_addr: got %0d want 0", wa0[0]); end
            n_cmp++; if (wd0[0] !== 24'h563412) begin n_err++; $display("FAIL single_data: got %h want 563412", wd0[0]); end
        end
        n_cmp++; if (if0.cfg_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", if0.cfg_ready); end
    endtask

    // Runs a list of frames and compares writes against the expected good-frame order.
    task automatic run_load(input string tag, input int gap_pct, input int bad_idx);
        logic [23:0] w[6];
        logic [23:0] exp_w[$];
        int nfr;
        do_reset();
        nfr = (bad_idx >= 0) ? 6 : 5;
        for (int k = 0; k < nfr; k++) begin
            w[k] = 24'($urandom);
            if (k != bad_idx) exp_w.push_back(w[k]);
        end
        for (int k = 0; k < nfr; k++) send_bytes(make_frame(w[k], k == bad_idx), gap_pct);
        repeat (4) @(negedge clk);
        n_cmp++; if (wa0.size() !== NODES) begin n_err++; $display("FAIL %s_count: got %0d want %0d", tag, wa0.size(), NODES); end
        for (int k = 0; k < NODES && k < wa0.size(); k++) begin
            n_cmp++; if (wa0[k] !== k || wd0[k] !== exp_w[k]) begin
                n_err++; $display("FAIL %s_write%0d: got %0d/%h want %0d/%h", tag, k, wa0[k], wd0[k], k, exp_w[k]);
            end
            if (k < wd1.size()) begin
                n_cmp++; if (wd1[k] !== 20'(exp_w[k] % (1 << 20))) begin
                    n_err++; $display("FAIL %s_write20_%0d: got %h want %h", tag, k, wd1[k], 20'(exp_w[k] % (1 << 20)));
                end
            end
        end
        n_cmp++; if (done0 !== 1'b1) begin n_err++; $display("FAIL %s_done: got %b want 1", tag, done0); end
        n_cmp++; if (csum_cnt0 !== ((bad_idx >= 0) ? 1 : 0)) begin n_err++; $display("FAIL %s_csum: got %0d want %0d", tag, csum_cnt0, (bad_idx >= 0) ? 1 : 0); end
    endtask

    task automatic test_back_to_back();
        int tf;
        run_load("b2b", 0, -1);
        tf = t_first;
        // First byte accepted at edge tf; last node's write ends NODES*(NB+2)-1 edges later.
        n_cmp++; if (done_cyc0 !== tf + NODES * (NB + 2) - 1) begin
            n_err++; $display("FAIL b2b_done_time: got %0d want %0d", done_cyc0 - tf, NODES * (NB + 2) - 1);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); cfg_valid = 1'b1; cfg_byte = 8'($urandom);
        end
        @(negedge clk); cfg_valid = 1'b0;
        n_cmp++; if (wa0.size() !== NODES) begin n_err++; $display("FAIL b2b_after_done_writes: got %0d want %0d", wa0.size(), NODES); end
        n_cmp++; if (if0.cfg_ready !== 1'b0 || done0 !== 1'b1) begin
            n_err++; $display("FAIL b2b_after_done: got ready=%b done=%b want 0/1", if0.cfg_ready, done0);
        end
    endtask

    task automatic test_bad_csum();
        bq_t q;
        do_reset();
        q = '{8'h12, 8'h34, 8'h56, 8'h71};
        send_bytes(q, 0);
        repeat (3) @(negedge clk);
        n_cmp++; if (csum_cnt0 !== 1) begin n_err++; $display("FAIL bad_csum_pulse: got %0d want 1", csum_cnt0); end
        n_cmp++; if (errc0 !== 8'd1) begin n_err++; $display("FAIL bad_errc: got %0d want 1", errc0); end
        n_cmp++; if (wa0.size() !== 0) begin n_err++; $display("FAIL bad_nowrite: got %0d want 0", wa0.size()); end
        send_bytes(make_frame(24'hA5C3E1, 1'b0), 0);
        repeat (3) @(negedge clk);
        n_cmp++; if (wa0.size() !== 1 || (wa0.size() > 0 && (wa0[0] !== 0 || wd0[0] !== 24'hA5C3E1))) begin
            n_err++; $display("FAIL bad_then_good: got count=%0d want 1 at addr 0 data a5c3e1", wa0.size());
        end
    endtask

    task automatic test_gapped();
        run_load("gap", 40, int'($urandom_range(5)));
    endtask

    task automatic test_restart();
        bq_t q;
        logic [23:0] w;
        int nw;
        do_reset();
        for (int k = 0; k < 3; k++) send_bytes(make_frame(24'($urandom), 1'b0), 0);
        send_bytes(make_frame(24'($urandom), 1'b1), 0);
        q = make_frame(24'($urandom), 1'b0);
        q = q[0:1];
        send_bytes(q, 0);
        @(negedge clk); restart = 1'b1; cfg_valid = 1'b1; cfg_byte = 8'h5A;
        @(negedge clk); restart = 1'b0; cfg_valid = 1'b0;
        w = 24'($urandom);
        send_bytes(make_frame(w, 1'b0), 0);
        repeat (3) @(negedge clk);
        n_cmp++; if (wa0.size() !== 4 || (wa0.size() == 4 && (wa0[3] !== 0 || wd0[3] !== w))) begin
            n_err++; $display("FAIL restart_next_write: got count=%0d want 4 ending at addr 0 data %h", wa0.size(), w);
        end
        n_cmp++; if (done0 !== 1'b0) begin n_err++; $display("FAIL restart_done: got %b want 0", done0); end
        n_cmp++; if (errc0 !== 8'd1) begin n_err++; $display("FAIL restart_errc_kept: got %0d want 1", errc0); end
        // Restart landing in the write cycle suppresses that write.
        send_bytes(make_frame(24'($urandom), 1'b0), 0);
        n_cmp++; if (if0.wr_node !== 1'b1) begin n_err++; $display("FAIL restart_wr_before: got %b want 1", if0.wr_node); end
        restart = 1'b1;
        #1;
        n_cmp++; if (if0.wr_node !== 1'b0) begin n_err++; $display("FAIL restart_wr_suppress: got %b want 0", if0.wr_node); end
        @(posedge clk); #1; restart = 1'b0;
        nw = wa0.size();
        w = 24'($urandom);
        send_bytes(make_frame(w, 1'b0), 0);
        repeat (3) @(negedge clk);
        n_cmp++; if (wa0.size() !== nw + 1 || (wa0.size() == nw + 1 && (wa0[nw] !== 0 || wd0[nw] !== w))) begin
            n_err++; $display("FAIL restart_in_write: got count=%0d want %0d ending at addr 0", wa0.size(), nw + 1);
        end
        n_cmp++; if (nw !== 4) begin n_err++; $display("FAIL restart_write_count: got %0d want 4", nw); end
    endtask

    task automatic test_reset_midframe();
        bq_t q;
        logic [23:0] w;
        do_reset();
        send_bytes(make_frame(24'($urandom), 1'b1), 0);
        send_bytes(make_frame(24'h00FFFF | 24'h800000, 1'b0), 0);
        q = make_frame(24'($urandom), 1'b0);
        q = q[0:1];
        send_bytes(q, 0);
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (errc0 !== 8'd0 || if0.node_addr !== 3'd0 || if0.node_data_in !== 24'h0) begin
            n_err++; $display("FAIL async_reset_regs: got err=%0d addr=%0d data=%h want 0/0/0", errc0, if0.node_addr, if0.node_data_in);
        end
        n_cmp++; if (if0.cfg_ready !== 1'b1 || if0.wr_node !== 1'b0 || done0 !== 1'b0 || csum0 !== 1'b0) begin
            n_err++; $display("FAIL async_reset_ctl: got ready=%b wr=%b done=%b csum=%b want 1/0/0/0", if0.cfg_ready, if0.wr_node, done0, csum0);
        end
        @(negedge clk); reset = 1'b0;
        clear_mon();
        w = 24'($urandom);
        send_bytes(make_frame(w, 1'b0), 0);
        repeat (3) @(negedge clk);
        n_cmp++; if (wa0.size() !== 1 || (wa0.size() == 1 && (wa0[0] !== 0 || wd0[0] !== w))) begin
            n_err++; $display("FAIL reset_partial_discard: got count=%0d want 1 at addr 0 data %h", wa0.size(), w);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 260; k++) send_bytes(make_frame(24'($urandom), 1'b1), 0);
        repeat (3) @(negedge clk);
        n_cmp++; if (errc0 !== 8'd255) begin n_err++; $display("FAIL sat_errc: got %0d want 255", errc0); end
        n_cmp++; if (csum_cnt0 !== 260) begin n_err++; $display("FAIL sat_pulses: got %0d want 260", csum_cnt0); end
        n_cmp++; if (wa0.size() !== 0) begin n_err++; $display("FAIL sat_nowrite: got %0d want 0", wa0.size()); end
    endtask

    task automatic test_padding();
        logic [23:0] w;
        bq_t q;
        do_reset();
        w = {4'(1 + $urandom_range(14)), 20'($urandom)};
        send_bytes(make_frame(w, 1'b0), 0);
        repeat (3) @(negedge clk);
        n_cmp++; if (wd1.size() !== 1 || (wd1.size() == 1 && wd1[0] !== 20'(w % (1 << 20)))) begin
            n_err++; $display("FAIL pad_data20: got count=%0d want 1 with data %h", wd1.size(), 20'(w % (1 << 20)));
        end
        n_cmp++; if (wd0.size() !== 1 || (wd0.size() == 1 && wd0[0] !== w)) begin
            n_err++; $display("FAIL pad_data24: got count=%0d want 1 with data %h", wd0.size(), w);
        end
        n_cmp++; if (csum_cnt1 !== 0) begin n_err++; $display("FAIL pad_good_csum: got %0d want 0", csum_cnt1); end
        // Checksum that leaves out the padding nibble must be rejected.
        q = make_frame(w, 1'b0);
        q[3] = w[7:0] ^ w[15:8] ^ (w[23:16] & 8'h0F);
        send_bytes(q, 0);
        repeat (3) @(negedge clk);
        n_cmp++; if (csum_cnt1 !== 1 || errc1 !== 8'd1 || wd1.size() !== 1) begin
            n_err++; $display("FAIL pad_csum_covers_pad: got pulses=%0d err=%0d writes=%0d want 1/1/1", csum_cnt1, errc1, wd1.size());
        end
    endtask

    initial begin
        reset = 1'b1; restart = 1'b0; cfg_valid = 1'b0; cfg_byte = 8'h00;
        clear_mon();
        test_reset();
        test_single_node();
        test_back_to_back();
        test_bad_csum();
        test_gapped();
        test_restart();
        test_reset_midframe();
        test_saturation();
        test_padding();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
